// File: rtl/cpu_onchip_memory_stream_reader.sv
// Block read master: streams a contiguous run of memory words out on a valid/ready port.
// Latency: first word on out_valid 3 cycles after the start cycle, then one word per cycle.
// Backpressure: out_ready low stalls the stream; reads stop once FIFO entries plus the in-flight read fill FIFO_DEPTH.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   start/start_addr/word_count - command (count 0 = no-op, >2^ADDR_W clamps)
//   busy, done                 - command status (done is a one-cycle pulse)
//   mem_*                      - read master to the single-port memory (1-cycle read latency)
//   out_data/out_valid/out_ready/out_last - stream source, last word tagged
module cpu_onchip_memory_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     remaining_q;
  logic                inflight_q;
  logic                last_pending_q;
  logic                done_q, done_d;
  logic                issue;
  logic [ADDR_W:0]     n_clamped;

  // FIFO state
  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    fifo_count_q;
  logic [CNT_W-1:0]    credit_used;
  logic [DATA_W:0]     rd_entry;
  logic                push, pop;

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  assign n_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

  // Registered counts only: a pop in this cycle does not free a credit until
  // next cycle, which keeps the issue path off the out_ready timing path.
  assign credit_used = fifo_count_q + CNT_W'(inflight_q);

  assign push      = inflight_q;
  assign out_valid = (fifo_count_q != '0);
  assign pop       = out_valid & out_ready;
  assign rd_entry  = fifo_mem[rd_ptr_q];
  // Gate with valid so the port reads zero whenever nothing is presented.
  assign out_data  = out_valid ? rd_entry[DATA_W-1:0] : '0;
  assign out_last  = out_valid & rd_entry[DATA_W];

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_clamped == '0) done_d  = 1'b1;
          else                 state_d = READ;
        end
      end
      READ: begin
        if (credit_used < CNT_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (remaining_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The tagged word is the last one pushed, so its transfer means the
        // FIFO is empty and nothing is in flight on the next cycle.
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      inflight_q     <= 1'b0;
      last_pending_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && start && n_clamped != '0) begin
        addr_q      <= start_addr;
        remaining_q <= n_clamped;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - (ADDR_W+1)'(1);
      end
      inflight_q     <= issue;
      last_pending_q <= issue && (remaining_q == (ADDR_W+1)'(1));
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {last_pending_q, mem_readdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_cpu_onchip_memory_stream_reader.sv
// Directed bench for cpu_onchip_memory_stream_reader with a 1-cycle-latency memory model.
module tb_cpu_onchip_memory_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done;
  logic [9:0]  mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = '0;
  logic [31:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;

  cpu_onchip_memory_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_model [1024];
  initial for (int k = 0; k < 1024; k++) mem_model[k] = k * 32'h01010101;

  always @(posedge clk) if (mem_chipselect) mem_readdata <= mem_model[mem_address];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Per-run observations
  int          cs_n, cs_stall_n, cs_first, cs_last;
  logic [9:0]  cs_addr [$];
  logic [31:0] w_data [$];
  bit          w_last [$];
  int          w_cyc [$];
  int          done_n, done_cyc, valid_n;
  bit          busy1, busy_at_done;
  logic [31:0] hold_data;
  bit          hold_valid;
  logic [31:0] rs_flags, rs_addr, rs_data;

  task automatic run_cmd(input int a, input int cnt, input int stall,
                         input int rst_cyc, input int restart_cyc, input int max_cyc);
    cs_n = 0; cs_stall_n = 0; cs_first = -1; cs_last = -1;
    cs_addr.delete(); w_data.delete(); w_last.delete(); w_cyc.delete();
    done_n = 0; done_cyc = -1; valid_n = 0; busy1 = 0; busy_at_done = 1;
    hold_data = '0; hold_valid = 0;
    rs_flags = 32'hFFFF_FFFF; rs_addr = 32'hFFFF_FFFF; rs_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 10'(a); word_count = 11'(cnt);
    out_ready = (stall == 0);
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (mem_chipselect) begin
        cs_n++;
        if (cyc < stall) cs_stall_n++;
        if (cs_first < 0) cs_first = cyc;
        cs_last = cyc;
        cs_addr.push_back(mem_address);
      end
      if (out_valid) valid_n++;
      if (out_valid && out_ready) begin
        w_data.push_back(out_data);
        w_last.push_back(out_last);
        w_cyc.push_back(cyc);
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      if (cyc == 1) busy1 = busy;
      if (stall > 0 && cyc == stall - 1) begin
        hold_valid = out_valid; hold_data = out_data;
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        rs_flags = {27'd0, busy, done, mem_chipselect, out_valid, out_last};
        rs_addr  = {22'd0, mem_address};
        rs_data  = out_data;
      end
      if (done_n > 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
      start     = (cyc + 1 == restart_cyc);
      if (cyc + 1 == restart_cyc) begin start_addr = 10'd700; word_count = 11'd9; end
      out_ready = (cyc + 1 >= stall);
      reset     = (cyc + 1 == rst_cyc);
    end
    start = 1'b0; reset = 1'b0; out_ready = 1'b1;
  endtask

  task automatic chk_words(input string tag, input int a, input int n);
    int errs = 0;
    int lasts = 0;
    chk({tag, "_nwords"}, w_data.size(), n);
    for (int i = 0; i < w_data.size(); i++) begin
      if (w_data[i] !== mem_model[(a + i) % 1024]) errs++;
      if (w_last[i]) lasts++;
    end
    chk({tag, "_data_errs"}, errs, 0);
    chk({tag, "_last_cnt"}, lasts, 1);
    if (w_data.size() > 0) chk({tag, "_last_pos"}, 32'(w_last[w_data.size()-1]), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_flags", {27'd0, busy, done, mem_chipselect, out_valid, out_last}, 0);
    chk("rst_addr", {22'd0, mem_address}, 0);
    chk("rst_data", out_data, 0);
    chk("const_pins", {25'd0, mem_write, mem_byteenable, mem_clken}, 32'h1F);
    @(posedge clk); #1; reset = 1'b0;

    // Basic: 3 words from address 5
    run_cmd(5, 3, 0, -1, -1, 40);
    chk("basic_cs_n", cs_n, 3);
    chk("basic_cs_first", cs_first, 1);
    chk("basic_cs_last", cs_last, 3);
    chk("basic_busy1", 32'(busy1), 1);
    chk_words("basic", 5, 3);
    if (w_data.size() == 3) begin
      chk("basic_w0", w_data[0], 32'h05050505);
      chk("basic_w2", w_data[2], 32'h07070707);
      chk("basic_first_cyc", w_cyc[0], 3);
      chk("basic_last_cyc", w_cyc[2], 5);
    end
    chk("basic_done_cyc", done_cyc, 6);
    chk("basic_done_n", done_n, 1);
    chk("basic_busy_at_done", 32'(busy_at_done), 0);

    // Wrap across the top of memory
    run_cmd(1022, 4, 0, -1, -1, 40);
    chk("wrap_cs_n", cs_n, 4);
    if (cs_addr.size() == 4) begin
      chk("wrap_a0", cs_addr[0], 1022);
      chk("wrap_a1", cs_addr[1], 1023);
      chk("wrap_a2", cs_addr[2], 0);
      chk("wrap_a3", cs_addr[3], 1);
    end
    chk_words("wrap", 1022, 4);
    chk("wrap_done_cyc", done_cyc, 7);

    // Backpressure: stalled for 20 cycles
    run_cmd(50, 10, 20, -1, -1, 80);
    chk("bp_cs_stalled", cs_stall_n, 4);
    chk("bp_cs_n", cs_n, 10);
    chk("bp_hold_valid", 32'(hold_valid), 1);
    chk("bp_hold_data", hold_data, mem_model[50]);
    chk_words("bp", 50, 10);
    chk("bp_done_n", done_n, 1);

    // Zero-length command
    run_cmd(9, 0, 0, -1, -1, 10);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_done_n", done_n, 1);
    chk("zero_cs_n", cs_n, 0);
    chk("zero_valid_n", valid_n, 0);

    // Oversized count clamps to a full pass of memory
    run_cmd(100, 2000, 0, -1, -1, 1100);
    chk("big_cs_n", cs_n, 1024);
    chk_words("big", 100, 1024);
    chk("big_done_cyc", done_cyc, 1027);

    // Reset in the middle of a command
    run_cmd(0, 8, 0, 4, -1, 20);
    chk("mid_rst_flags", rs_flags, 0);
    chk("mid_rst_addr", rs_addr, 0);
    chk("mid_rst_data", rs_data, 0);
    chk("mid_rst_no_done", done_n, 0);
    run_cmd(200, 2, 0, -1, -1, 20);
    chk_words("post_rst", 200, 2);
    chk("post_rst_done_cyc", done_cyc, 5);

    // Second start while busy is ignored
    run_cmd(300, 6, 0, -1, 3, 40);
    chk("busy_start_cs_n", cs_n, 6);
    chk_words("busy_start", 300, 6);
    chk("busy_start_done_n", done_n, 1);
    chk("busy_start_done_cyc", done_cyc, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
